// File: rtl/l2_port_scheduler_if.sv
// Bundle of the L1 I/D miss ports, the shared L2 port and the pipeline enable.
// master = the environment (caches, L2); slave = l2_port_scheduler.
interface l2_port_scheduler_if #(
    parameter int ADDR_W  = 16,
    parameter int BLOCK_W = 128
);
    logic               icache_pmem_read;
    logic [ADDR_W-1:0]  icache_pmem_address;
    logic               icache_pmem_resp;

    logic               dcache_pmem_read;
    logic               dcache_pmem_write;
    logic [ADDR_W-1:0]  dcache_pmem_address;
    logic [BLOCK_W-1:0] dcache_pmem_wdata;
    logic               dcache_pmem_resp;

    logic [ADDR_W-1:0]  l2_address;
    logic [BLOCK_W-1:0] l2_wdata;
    logic               l2_read;
    logic               l2_write;
    logic               l2_resp;

    logic               ld_regs;

    modport master (
        output icache_pmem_read, icache_pmem_address,
        output dcache_pmem_read, dcache_pmem_write, dcache_pmem_address, dcache_pmem_wdata,
        output l2_resp,
        input  icache_pmem_resp, dcache_pmem_resp,
        input  l2_address, l2_wdata, l2_read, l2_write,
        input  ld_regs
    );

    modport slave (
        input  icache_pmem_read, icache_pmem_address,
        input  dcache_pmem_read, dcache_pmem_write, dcache_pmem_address, dcache_pmem_wdata,
        input  l2_resp,
        output icache_pmem_resp, dcache_pmem_resp,
        output l2_address, l2_wdata, l2_read, l2_write,
        output ld_regs
    );
endinterface

// File: rtl/l2_port_scheduler.sv
// Arbiter for the single L2 port between I-cache fills and D-cache fills/write-backs.
// Optional macro L2_SCHED_PERF_EN adds saturating grant/conflict performance counters.
module l2_port_scheduler #(
    parameter int ADDR_W       = 16,
    parameter int BLOCK_W      = 128,
    parameter int STARVE_LIMIT = 4,
    parameter int STARVE_W     = 3
) (
    input  logic                 clk,
    input  logic                 rst_n,
    l2_port_scheduler_if.slave   bus
`ifdef L2_SCHED_PERF_EN
    ,
    output logic [15:0]          perf_i_grants,
    output logic [15:0]          perf_d_grants,
    output logic [15:0]          perf_conflict_cycles
`endif
);

    typedef enum logic [1:0] {IDLE, GRANT_I, GRANT_D, RELEASE} state_t;
    typedef enum logic [1:0] {OWN_NONE, OWN_I, OWN_D} owner_t;

    localparam logic [STARVE_W-1:0] LIMIT = STARVE_W'(STARVE_LIMIT);

    state_t              state, state_next;
    owner_t              owner;
    logic [STARVE_W-1:0] starve_cnt;

    logic [ADDR_W-1:0]   l2_address_q;
    logic [BLOCK_W-1:0]  l2_wdata_q;
    logic                l2_read_q;
    logic                l2_write_q;

    logic req_i, req_d;
    logic starved;
    logic grant_i, grant_d;
    logic resp_i, resp_d;
    logic done;

    // The L1 that just finished still holds its strobe during RELEASE; hide it
    // so it can neither re-win arbitration nor stall the pipeline.
    assign req_i = bus.icache_pmem_read
                 & ~((state == RELEASE) && (owner == OWN_I));
    assign req_d = (bus.dcache_pmem_read | bus.dcache_pmem_write)
                 & ~((state == RELEASE) && (owner == OWN_D));

    assign starved = req_i && (starve_cnt == LIMIT);

    // NOTE: every signal driven from always_comb gets a default at the top,
    // so no path through the case statement can leave it unassigned (no latch).
    always_comb begin
        state_next = state;
        grant_i    = 1'b0;
        grant_d    = 1'b0;
        resp_i     = 1'b0;
        resp_d     = 1'b0;

        unique case (state)
            IDLE: begin
                if (req_d && !starved) begin
                    state_next = GRANT_D;
                    grant_d    = 1'b1;
                end else if (req_i) begin
                    state_next = GRANT_I;
                    grant_i    = 1'b1;
                end
            end
            GRANT_I: begin
                resp_i = bus.l2_resp;
                if (bus.l2_resp) state_next = RELEASE;
            end
            GRANT_D: begin
                resp_d = bus.l2_resp;
                if (bus.l2_resp) state_next = RELEASE;
            end
            RELEASE: state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    assign done = resp_i | resp_d;

    // NOTE: registers are written with <= only, so every flop samples the
    // pre-edge values of its neighbours regardless of statement order.
    always_ff @(posedge clk) begin
        if (!rst_n) state <= IDLE;
        else        state <= state_next;
    end

    // Request latch: captured on the grant edge, frozen until the L2 answers.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            l2_address_q <= '0;
            l2_wdata_q   <= '0;
            l2_read_q    <= 1'b0;
            l2_write_q   <= 1'b0;
        end else if (grant_d) begin
            l2_address_q <= bus.dcache_pmem_address;
            l2_wdata_q   <= bus.dcache_pmem_wdata;
            l2_write_q   <= bus.dcache_pmem_write;
            l2_read_q    <= ~bus.dcache_pmem_write;
        end else if (grant_i) begin
            l2_address_q <= bus.icache_pmem_address;
            l2_read_q    <= 1'b1;
            l2_write_q   <= 1'b0;
        end else if (done) begin
            l2_read_q    <= 1'b0;
            l2_write_q   <= 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            owner <= OWN_NONE;
        end else if (grant_d) begin
            owner <= OWN_D;
        end else if (grant_i) begin
            owner <= OWN_I;
        end else if (state == RELEASE) begin
            owner <= OWN_NONE;
        end
    end

    // Counts consecutive D wins that left the I-cache waiting.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            starve_cnt <= '0;
        end else if (grant_d) begin
            if (!req_i)                   starve_cnt <= '0;
            else if (starve_cnt != LIMIT) starve_cnt <= starve_cnt + 1'b1;
        end else if (grant_i) begin
            starve_cnt <= '0;
        end
    end

    assign bus.l2_address       = l2_address_q;
    assign bus.l2_wdata         = l2_wdata_q;
    assign bus.l2_read          = l2_read_q;
    assign bus.l2_write         = l2_write_q;
    assign bus.icache_pmem_resp = resp_i;
    assign bus.dcache_pmem_resp = resp_d;
    assign bus.ld_regs          = ~((req_i & ~resp_i) | (req_d & ~resp_d));

`ifdef L2_SCHED_PERF_EN
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            perf_i_grants        <= '0;
            perf_d_grants        <= '0;
            perf_conflict_cycles <= '0;
        end else begin
            if (grant_i && perf_i_grants != 16'hFFFF)
                perf_i_grants <= perf_i_grants + 16'd1;
            if (grant_d && perf_d_grants != 16'hFFFF)
                perf_d_grants <= perf_d_grants + 16'd1;
            if (req_i && req_d && perf_conflict_cycles != 16'hFFFF)
                perf_conflict_cycles <= perf_conflict_cycles + 16'd1;
        end
    end
`endif

endmodule

// File: tb/tb_l2_port_scheduler.sv
// Self-checking bench for l2_port_scheduler: directed vector table, starvation
// sequence and randomized transactions against a transaction-level model.
module tb_l2_port_scheduler;

    localparam int ADDR_W  = 16;
    localparam int BLOCK_W = 128;
    localparam int LIMIT   = 4;

    logic clk = 1'b0;
    logic rst_n;
    always #5 clk = ~clk;

    l2_port_scheduler_if #(.ADDR_W(ADDR_W), .BLOCK_W(BLOCK_W)) bus ();

`ifdef L2_SCHED_PERF_EN
    logic [15:0] perf_i, perf_d, perf_c;
`endif

    l2_port_scheduler #(
        .ADDR_W(ADDR_W), .BLOCK_W(BLOCK_W), .STARVE_LIMIT(LIMIT), .STARVE_W(3)
    ) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus.slave)
`ifdef L2_SCHED_PERF_EN
        ,
        .perf_i_grants        (perf_i),
        .perf_d_grants        (perf_d),
        .perf_conflict_cycles (perf_c)
`endif
    );

    int n_checks = 0;
    int n_fail   = 0;

    task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h, expected %0h", name, act, exp);
        end
    endtask

    typedef struct {
        logic               rst_n, ir;
        logic [15:0]        ia;
        logic               dr, dw;
        logic [15:0]        da;
        logic [127:0]       dwd;
        logic               resp;
        logic               e_rd, e_wr;
        logic [15:0]        e_addr;
        logic [127:0]       e_wdata;
        logic               e_iresp, e_dresp, e_ld;
    } vec_t;

    vec_t vecs[$];

    function automatic vec_t mk(
        logic r, logic ir, logic [15:0] ia, logic dr, logic dw, logic [15:0] da,
        logic [127:0] dwd, logic resp, logic e_rd, logic e_wr, logic [15:0] e_addr,
        logic [127:0] e_wdata, logic e_iresp, logic e_dresp, logic e_ld);
        vec_t v;
        v.rst_n = r;  v.ir = ir; v.ia = ia; v.dr = dr; v.dw = dw; v.da = da;
        v.dwd = dwd;  v.resp = resp;
        v.e_rd = e_rd; v.e_wr = e_wr; v.e_addr = e_addr; v.e_wdata = e_wdata;
        v.e_iresp = e_iresp; v.e_dresp = e_dresp; v.e_ld = e_ld;
        return v;
    endfunction

    task automatic clear_inputs();
        bus.icache_pmem_read    = 1'b0;
        bus.icache_pmem_address = '0;
        bus.dcache_pmem_read    = 1'b0;
        bus.dcache_pmem_write   = 1'b0;
        bus.dcache_pmem_address = '0;
        bus.dcache_pmem_wdata   = '0;
        bus.l2_resp             = 1'b0;
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        clear_inputs();
        @(negedge clk);
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    initial begin
        #400000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    // Directed table: one record per clock cycle, inputs driven after the
    // falling edge, outputs compared 1 time unit later.
    initial begin
        logic [127:0] aa;
        logic [15:0]  exp_order [10];
        int           grants, hold;
        int           starve;
        logic [15:0]  m_addr;
        logic [127:0] m_wdata;
`ifdef L2_SCHED_PERF_EN
        logic [15:0]  p_i, p_d, p_c;
`endif

        aa = {16{8'hA5}};
        do_reset();

        //            rst ir ia       dr dw da       dwd  rsp  rd wr addr     wdata ir dr ld
        vecs.push_back(mk(1, 0, 16'h0000, 0, 0, 16'h0000, '0, 0,   0, 0, 16'h0000, '0,   0, 0, 1)); // 0 reset state
        vecs.push_back(mk(1, 1, 16'h0040, 0, 0, 16'h0000, '0, 0,   0, 0, 16'h0000, '0,   0, 0, 0)); // 1 lone I
        vecs.push_back(mk(1, 1, 16'h0040, 0, 0, 16'h0000, '0, 0,   1, 0, 16'h0040, '0,   0, 0, 0)); // 2
        vecs.push_back(mk(1, 1, 16'h0040, 0, 0, 16'h0000, '0, 0,   1, 0, 16'h0040, '0,   0, 0, 0)); // 3
        vecs.push_back(mk(1, 1, 16'h0040, 0, 0, 16'h0000, '0, 0,   1, 0, 16'h0040, '0,   0, 0, 0)); // 4
        vecs.push_back(mk(1, 1, 16'h0040, 0, 0, 16'h0000, '0, 1,   1, 0, 16'h0040, '0,   1, 0, 1)); // 5 resp
        vecs.push_back(mk(1, 0, 16'h0000, 0, 0, 16'h0000, '0, 0,   0, 0, 16'h0040, '0,   0, 0, 1)); // 6 release
        vecs.push_back(mk(1, 0, 16'h0000, 0, 0, 16'h0000, '0, 0,   0, 0, 16'h0040, '0,   0, 0, 1)); // 7 idle
        vecs.push_back(mk(1, 1, 16'h0080, 0, 1, 16'h1200, aa, 0,   0, 0, 16'h0040, '0,   0, 0, 0)); // 8 I + D wb
        vecs.push_back(mk(1, 1, 16'h0080, 0, 1, 16'h2000, aa, 0,   0, 1, 16'h1200, aa,   0, 0, 0)); // 9 addr change
        vecs.push_back(mk(1, 1, 16'h0080, 0, 1, 16'h2000, aa, 0,   0, 1, 16'h1200, aa,   0, 0, 0)); // 10
        vecs.push_back(mk(1, 1, 16'h0080, 0, 1, 16'h2000, aa, 1,   0, 1, 16'h1200, aa,   0, 1, 0)); // 11 D resp
        vecs.push_back(mk(1, 1, 16'h0080, 0, 0, 16'h0000, aa, 0,   0, 0, 16'h1200, aa,   0, 0, 0)); // 12 release
        vecs.push_back(mk(1, 1, 16'h0080, 0, 0, 16'h0000, aa, 0,   0, 0, 16'h1200, aa,   0, 0, 0)); // 13 I decided
        vecs.push_back(mk(1, 1, 16'h0080, 0, 0, 16'h0000, aa, 0,   1, 0, 16'h0080, aa,   0, 0, 0)); // 14 I granted
        vecs.push_back(mk(1, 1, 16'h0080, 0, 0, 16'h0000, aa, 0,   1, 0, 16'h0080, aa,   0, 0, 0)); // 15
        vecs.push_back(mk(1, 1, 16'h0080, 0, 0, 16'h0000, aa, 1,   1, 0, 16'h0080, aa,   1, 0, 1)); // 16 I resp
        vecs.push_back(mk(1, 0, 16'h0000, 0, 0, 16'h0000, aa, 0,   0, 0, 16'h0080, aa,   0, 0, 1)); // 17
        vecs.push_back(mk(1, 0, 16'h0000, 0, 0, 16'h0000, aa, 0,   0, 0, 16'h0080, aa,   0, 0, 1)); // 18
        vecs.push_back(mk(1, 0, 16'h0000, 0, 0, 16'h0000, aa, 1,   0, 0, 16'h0080, aa,   0, 0, 1)); // 19 spurious
        vecs.push_back(mk(1, 0, 16'h0000, 0, 0, 16'h0000, aa, 0,   0, 0, 16'h0080, aa,   0, 0, 1)); // 20
        vecs.push_back(mk(1, 0, 16'h0000, 1, 0, 16'h0300, aa, 0,   0, 0, 16'h0080, aa,   0, 0, 0)); // 21 D read
        vecs.push_back(mk(1, 0, 16'h0000, 1, 0, 16'h0300, aa, 0,   1, 0, 16'h0300, aa,   0, 0, 0)); // 22
        vecs.push_back(mk(0, 0, 16'h0000, 1, 0, 16'h0300, aa, 0,   1, 0, 16'h0300, aa,   0, 0, 0)); // 23 reset
        vecs.push_back(mk(1, 0, 16'h0000, 0, 0, 16'h0300, aa, 1,   0, 0, 16'h0000, '0,   0, 0, 1)); // 24 late resp
        vecs.push_back(mk(1, 0, 16'h0000, 0, 0, 16'h0000, '0, 0,   0, 0, 16'h0000, '0,   0, 0, 1)); // 25

        for (int i = 0; i < vecs.size(); i++) begin
`ifdef L2_SCHED_PERF_EN
            if (i == 19) begin p_i = perf_i; p_d = perf_d; p_c = perf_c; end
            if (i == 21) begin
                check("perf spurious resp", {perf_i, perf_d, perf_c}, {p_i, p_d, p_c});
            end
`endif
            rst_n                   = vecs[i].rst_n;
            bus.icache_pmem_read    = vecs[i].ir;
            bus.icache_pmem_address = vecs[i].ia;
            bus.dcache_pmem_read    = vecs[i].dr;
            bus.dcache_pmem_write   = vecs[i].dw;
            bus.dcache_pmem_address = vecs[i].da;
            bus.dcache_pmem_wdata   = vecs[i].dwd;
            bus.l2_resp             = vecs[i].resp;
            #1;
            check($sformatf("vec%0d l2_read", i),    bus.l2_read,          vecs[i].e_rd);
            check($sformatf("vec%0d l2_write", i),   bus.l2_write,         vecs[i].e_wr);
            check($sformatf("vec%0d l2_address", i), bus.l2_address,       vecs[i].e_addr);
            check($sformatf("vec%0d l2_wdata", i),   bus.l2_wdata,         vecs[i].e_wdata);
            check($sformatf("vec%0d icache_resp", i), bus.icache_pmem_resp, vecs[i].e_iresp);
            check($sformatf("vec%0d dcache_resp", i), bus.dcache_pmem_resp, vecs[i].e_dresp);
            check($sformatf("vec%0d ld_regs", i),    bus.ld_regs,          vecs[i].e_ld);
            @(negedge clk);
        end

        // Starvation: both caches request continuously; L2 answers on the
        // second strobe cycle of each grant.
        do_reset();
        exp_order = '{16'h1000, 16'h1000, 16'h1000, 16'h1000, 16'h2000,
                      16'h1000, 16'h1000, 16'h1000, 16'h1000, 16'h2000};
        bus.icache_pmem_read    = 1'b1;
        bus.icache_pmem_address = 16'h2000;
        bus.dcache_pmem_read    = 1'b1;
        bus.dcache_pmem_address = 16'h1000;
        grants = 0;
        hold   = 0;
        for (int cyc = 0; cyc < 300 && grants < 10; cyc++) begin
            #1;
            if (bus.l2_read || bus.l2_write) begin
                if (hold == 0) begin
                    check($sformatf("starve grant%0d", grants), bus.l2_address, exp_order[grants]);
                    grants++;
                end
                hold++;
                bus.l2_resp = (hold == 2);
                if (hold == 2) hold = 0;
            end else begin
                bus.l2_resp = 1'b0;
            end
            @(negedge clk);
        end
        if (grants < 10) check("starve grant budget", grants, 10);

        // Randomized transactions against a transaction-level model.
        do_reset();
        starve  = 0;
        m_addr  = '0;
        m_wdata = '0;
        for (int r = 0; r < 40; r++) begin
            int           sel, dkind, lat;
            bit           i_wait, d_wait, owner_d, other_wait, keep;
            logic [15:0]  ia, da;
            logic [127:0] dwd;
            bit           e_rd, e_wr;

            sel   = $urandom_range(0, 2);
            dkind = $urandom_range(0, 2);
            ia    = 16'($urandom);
            da    = 16'($urandom);
            dwd   = {$urandom, $urandom, $urandom, $urandom};
            i_wait = (sel != 1);
            d_wait = (sel != 0);
            e_rd = 1'b0;
            e_wr = 1'b0;

            bus.icache_pmem_read    = i_wait;
            bus.icache_pmem_address = ia;
            bus.dcache_pmem_read    = d_wait && (dkind != 1);
            bus.dcache_pmem_write   = d_wait && (dkind != 0);
            bus.dcache_pmem_address = da;
            bus.dcache_pmem_wdata   = dwd;
            bus.l2_resp             = 1'b0;

            while (i_wait || d_wait) begin
                owner_d = d_wait && !(i_wait && starve >= LIMIT);
                #1;
                check($sformatf("rnd%0d decide ld_regs", r), bus.ld_regs, 1'b0);
                check($sformatf("rnd%0d decide resp", r),
                      {bus.icache_pmem_resp, bus.dcache_pmem_resp}, 2'b00);
                if (owner_d) begin
                    starve  = i_wait ? ((starve < LIMIT) ? starve + 1 : LIMIT) : 0;
                    m_addr  = da;
                    m_wdata = dwd;
                    e_wr    = (dkind != 0);
                    e_rd    = (dkind == 0);
                end else begin
                    starve  = 0;
                    m_addr  = ia;
                    e_rd    = 1'b1;
                    e_wr    = 1'b0;
                end
                other_wait = owner_d ? i_wait : d_wait;
                @(negedge clk);

                lat = $urandom_range(1, 4);
                for (int k = 1; k <= lat; k++) begin
                    bus.l2_resp = (k == lat);
                    if (owner_d) bus.dcache_pmem_address = 16'($urandom);
                    else         bus.icache_pmem_address = 16'($urandom);
                    #1;
                    check($sformatf("rnd%0d l2_read", r),    bus.l2_read,    e_rd);
                    check($sformatf("rnd%0d l2_write", r),   bus.l2_write,   e_wr);
                    check($sformatf("rnd%0d l2_address", r), bus.l2_address, m_addr);
                    check($sformatf("rnd%0d l2_wdata", r),   bus.l2_wdata,   m_wdata);
                    check($sformatf("rnd%0d icache_resp", r), bus.icache_pmem_resp, !owner_d && k == lat);
                    check($sformatf("rnd%0d dcache_resp", r), bus.dcache_pmem_resp, owner_d && k == lat);
                    check($sformatf("rnd%0d grant ld_regs", r), bus.ld_regs, (k == lat) && !other_wait);
                    @(negedge clk);
                end

                // Release cycle: the finished L1 may still be holding its strobe.
                keep = $urandom_range(0, 1);
                bus.l2_resp = 1'b0;
                if (owner_d) begin
                    d_wait = 1'b0;
                    if (!keep) begin bus.dcache_pmem_read = 1'b0; bus.dcache_pmem_write = 1'b0; end
                end else begin
                    i_wait = 1'b0;
                    if (!keep) bus.icache_pmem_read = 1'b0;
                end
                #1;
                check($sformatf("rnd%0d release strobes", r), {bus.l2_read, bus.l2_write}, 2'b00);
                check($sformatf("rnd%0d release resp", r),
                      {bus.icache_pmem_resp, bus.dcache_pmem_resp}, 2'b00);
                check($sformatf("rnd%0d release ld_regs", r), bus.ld_regs, !other_wait);
                @(negedge clk);
                if (owner_d) begin bus.dcache_pmem_read = 1'b0; bus.dcache_pmem_write = 1'b0; end
                else         bus.icache_pmem_read = 1'b0;
            end

            #1;
            check($sformatf("rnd%0d idle ld_regs", r), bus.ld_regs, 1'b1);
            check($sformatf("rnd%0d idle strobes", r), {bus.l2_read, bus.l2_write}, 2'b00);
            @(negedge clk);
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/l2_port_scheduler.md
Name: l2_port_scheduler

Overview:
- Schedules the single shared L2 port between I-cache miss traffic (read only) and D-cache miss traffic (read and write-back).
- Latches the winning request and holds it stable to the L2 until the L2 responds, then routes the response back to the owner.
- Produces the pipeline-advance enable `ld_regs`, which gates every pipeline latch in the CPU.
- Default priority favours the D-cache; a starvation counter guarantees the I-cache a grant.

Parameters:
- ADDR_W, 16: L1/L2 address width (lc3b_word).
- BLOCK_W, 128: L1 block width (lc3b_c_block).
- STARVE_LIMIT, 4: consecutive D grants allowed while the I-cache waits before I is forced.
- STARVE_W, 3: starvation counter width; must hold STARVE_LIMIT.

Ports:
- clk  in  1  clock; all state updates on the rising edge.
- rst_n  in  1  synchronous active-low reset.
- icache_pmem_read  in  1  I-cache miss fill request.
- icache_pmem_address  in  ADDR_W  I-cache block address.
- icache_pmem_resp  out  1  I-cache transaction done.
- dcache_pmem_read  in  1  D-cache fill request.
- dcache_pmem_write  in  1  D-cache write-back request.
- dcache_pmem_address  in  ADDR_W  D-cache block address.
- dcache_pmem_wdata  in  BLOCK_W  D-cache write-back data.
- dcache_pmem_resp  out  1  D-cache transaction done.
- l2_address  out  ADDR_W  latched address to L2.
- l2_wdata  out  BLOCK_W  latched write data to L2.
- l2_read  out  1  L2 read strobe.
- l2_write  out  1  L2 write strobe.
- l2_resp  in  1  L2 done; single-cycle pulse.
- ld_regs  out  1  pipeline latch enable.

Behaviour:
- Clocking and reset: one clock `clk`; reset `rst_n` is synchronous, active-low.
- Reset values: state=IDLE, owner=NONE, starve_cnt=0, l2_read=0, l2_write=0, l2_address=0, l2_wdata=0. The resp outputs are 0 because state is not GRANT_*.
- States: IDLE, GRANT_I, GRANT_D, RELEASE.
- Request signals:
  - req_i = icache_pmem_read.
  - req_d = dcache_pmem_read | dcache_pmem_write.
  - In RELEASE, the previous owner's request is masked; the L1 drops its strobe the cycle after resp.
- IDLE decision, when a request is present in cycle N:
  - If req_d and not (req_i and starve_cnt==STARVE_LIMIT): go to GRANT_D.
  - Else if req_i: go to GRANT_I.
  - Else stay in IDLE.
- Grant latching:
  - On entry to GRANT_x (edge ending cycle N), latch the owner's address and wdata (wdata only for D).
  - Latch l2_read/l2_write. For D: l2_write=dcache_pmem_write and l2_read=!dcache_pmem_write; write wins if both are asserted.
  - The L2 sees the strobe at N+1, so request-to-strobe latency is 1 cycle.
- While in GRANT_x, the l2_* outputs hold constant. Any change on requester inputs is ignored.
- When l2_resp=1 in GRANT_x:
  - Owner resp=1 combinationally in the same cycle; the other resp stays 0.
  - l2_read/l2_write are cleared at the edge; next state is RELEASE.
- RELEASE lasts exactly 1 cycle, then the state goes to IDLE. A new grant is therefore possible from resp cycle +2.
- l2_resp outside GRANT_* is ignored; no resp is produced.
- Starvation counter:
  - On each GRANT_D entry while req_i=1: starve_cnt increments, saturating at STARVE_LIMIT.
  - On GRANT_I entry: starve_cnt clears to 0.
  - On GRANT_D entry while req_i=0: starve_cnt clears to 0.
- ld_regs = !(pending_i | pending_d).
  - pending_x = unmasked req_x & !x_pmem_resp.
  - ld_regs=1 in the resp cycle, during RELEASE, and in IDLE with no requests.
- Reset mid-transaction: the next edge forces IDLE and drops the strobes. A late l2_resp after that is ignored.

Optional Feature:
- Macro: L2_SCHED_PERF_EN.
- When defined, adds three outputs: perf_i_grants, perf_d_grants and perf_conflict_cycles, each 16 bits.
  - perf_i_grants and perf_d_grants count GRANT_I/GRANT_D entries.
  - perf_conflict_cycles counts cycles where req_i and req_d are both unmasked.
  - All three saturate at 16'hFFFF and reset to 0.
- When undefined, these ports and counters are absent. Arbitration behaviour is identical either way.

Test Plan:
- Lone I miss:
  - Stimulus: icache_pmem_read=1, address 16'h0040 at cycle 1; l2_resp at cycle 5.
  - Required: l2_read=1 with l2_address=16'h0040 in cycles 2-5; icache_pmem_resp=1 in cycle 5 only; l2_read=0 in cycle 6; ld_regs=0 in cycles 1-4 and 1 in cycle 5.
- Simultaneous I read and D write-back:
  - Stimulus: both requests at cycle 1, dcache address 16'h1200, wdata 128'hA5.., L2 answers after 3 cycles each.
  - Required: D served first (l2_write=1, l2_wdata=A5..); I granted 2 cycles after D's resp.
- Input change under grant:
  - Stimulus: dcache_pmem_address changes to 16'h2000 mid-GRANT_D.
  - Required: l2_address stays at the latched 16'h1200.
- Starvation, STARVE_LIMIT=4:
  - Stimulus: D requests continuously, I requests continuously.
  - Required: grant order D,D,D,D,I,D...; starve_cnt returns to 0 after the I grant.
- Reset mid-GRANT_D:
  - Stimulus: rst_n=0 for 1 cycle during GRANT_D, then l2_resp=1.
  - Required: strobes are 0 after the edge; dcache_pmem_resp stays 0; state is IDLE.
- Spurious l2_resp=1 in IDLE:
  - Required: both resp outputs stay 0; no state change.
  - With L2_SCHED_PERF_EN: counters unchanged.
